// File: rtl/fifo_rd_upsizer.sv
// fifo_rd_upsizer: packs RATIO first-word-fall-through FIFO words into one wide valid/ready beat.
// Rev 1.0 -- initial release; flush emits a partial beat with a contiguous lane-keep mask.
`default_nettype none

module fifo_rd_upsizer #(
  parameter int IN_WIDTH = 16,
  parameter int RATIO    = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [IN_WIDTH-1:0]       fifo_rdata_i,
  input  logic                      fifo_rempty_i,
  output logic                      fifo_rd_en_o,
  input  logic                      flush_i,
  output logic                      m_valid_o,
  output logic [IN_WIDTH*RATIO-1:0] m_data_o,
  output logic [RATIO-1:0]          m_keep_o,
  input  logic                      m_ready_i,
  output logic                      busy_o
);

  localparam int CNT_W = $clog2(RATIO) + 1;
  localparam int OUT_W = IN_WIDTH * RATIO;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]                cnt;
  logic [IN_WIDTH*(RATIO-1)-1:0]   acc;
  logic [OUT_W-1:0]                acc_ext;
  logic                            out_free;
  logic                            full_beat;
  logic                            flush_fire;
  logic [CNT_W-1:0]                n_lanes;
  logic [OUT_W-1:0]                flush_data;
  logic [RATIO-1:0]                flush_keep;

  assign acc_ext  = {{IN_WIDTH{1'b0}}, acc};
  assign out_free = !m_valid_o | m_ready_i;

  // The last lane can only be popped when the output register can take the beat.
  assign fifo_rd_en_o = !reset_i & !fifo_rempty_i & ((cnt < LAST_LANE) | out_free);
  assign full_beat    = fifo_rd_en_o & (cnt == LAST_LANE);
  assign n_lanes      = cnt + CNT_W'(fifo_rd_en_o);
  assign flush_fire   = flush_i & out_free & !full_beat & (n_lanes != '0);

  always_comb begin
    flush_data = '0;
    flush_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (CNT_W'(i) < cnt) begin
        flush_data[i*IN_WIDTH +: IN_WIDTH] = acc_ext[i*IN_WIDTH +: IN_WIDTH];
      end else if ((CNT_W'(i) == cnt) && fifo_rd_en_o) begin
        flush_data[i*IN_WIDTH +: IN_WIDTH] = fifo_rdata_i;
      end
      flush_keep[i] = (CNT_W'(i) < n_lanes);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt       <= '0;
      acc       <= '0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_keep_o  <= '0;
    end else if (full_beat) begin
      m_data_o  <= {fifo_rdata_i, acc};
      m_keep_o  <= '1;
      m_valid_o <= 1'b1;
      cnt       <= '0;
      acc       <= '0;
    end else if (flush_fire) begin
      m_data_o  <= flush_data;
      m_keep_o  <= flush_keep;
      m_valid_o <= 1'b1;
      cnt       <= '0;
      acc       <= '0;
    end else begin
      // Clearing data/keep on drain keeps keep==0 exactly when no beat is valid.
      if (m_ready_i) begin
        m_valid_o <= 1'b0;
        m_data_o  <= '0;
        m_keep_o  <= '0;
      end
      if (fifo_rd_en_o) begin
        acc[cnt*IN_WIDTH +: IN_WIDTH] <= fifo_rdata_i;
        cnt                           <= cnt + 1'b1;
      end
    end
  end

  assign busy_o = (cnt != '0) | m_valid_o;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_upsizer.sv
// tb_fifo_rd_upsizer: directed and randomized checks of fifo_rd_upsizer against a queue-based model.
// Rev 1.0
`default_nettype none

module tb_fifo_rd_upsizer;

  localparam int W = 16;
  localparam int R = 4;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [W-1:0]    fifo_rdata_i;
  logic            fifo_rempty_i;
  logic            fifo_rd_en_o;
  logic            flush_i;
  logic            m_valid_o;
  logic [W*R-1:0]  m_data_o;
  logic [R-1:0]    m_keep_o;
  logic            m_ready_i;
  logic            busy_o;

  fifo_rd_upsizer #(.IN_WIDTH(W), .RATIO(R)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rempty_i(fifo_rempty_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .flush_i      (flush_i),
    .m_valid_o    (m_valid_o),
    .m_data_o     (m_data_o),
    .m_keep_o     (m_keep_o),
    .m_ready_i    (m_ready_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Environment FIFO contents and reference model state.
  logic [W-1:0]   fq[$];
  logic [W-1:0]   accq[$];
  logic           mv;
  logic [W*R-1:0] md;
  logic [R-1:0]   mk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic load_beat();
    md = '0;
    mk = '0;
    foreach (accq[i]) begin
      md[i*W +: W] = accq[i];
      mk[i]        = 1'b1;
    end
    mv = 1'b1;
    accq.delete();
  endtask

  task automatic cycle(input logic rst, input logic fl, input logic rdy);
    logic         free;
    logic         pop;
    logic [W-1:0] word;
    reset_i       = rst;
    flush_i       = fl;
    m_ready_i     = rdy;
    fifo_rempty_i = (fq.size() == 0);
    fifo_rdata_i  = (fq.size() != 0) ? fq[0] : '0;
    @(negedge clk);
    free = !mv || rdy;
    pop  = !rst && (fq.size() != 0) && ((accq.size() < R-1) || free);
    word = (fq.size() != 0) ? fq[0] : '0;
    check("rd_en", 64'(fifo_rd_en_o), 64'(pop));
    check("valid", 64'(m_valid_o), 64'(mv));
    check("data",  64'(m_data_o),  64'(md));
    check("keep",  64'(m_keep_o),  64'(mk));
    check("busy",  64'(busy_o),    64'((accq.size() != 0) || mv));
    if (rst) begin
      mv = 1'b0;
      md = '0;
      mk = '0;
      accq.delete();
    end else if (pop && accq.size() == R-1) begin
      accq.push_back(word);
      load_beat();
    end else if (fl && free && (accq.size() + int'(pop)) > 0) begin
      if (pop) accq.push_back(word);
      load_beat();
    end else begin
      if (rdy) begin
        mv = 1'b0;
        md = '0;
        mk = '0;
      end
      if (pop) accq.push_back(word);
    end
    if (pop) void'(fq.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i       = 1'b1;
    flush_i       = 1'b0;
    m_ready_i     = 1'b0;
    fifo_rempty_i = 1'b1;
    fifo_rdata_i  = '0;
    mv = 1'b0;
    md = '0;
    mk = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(m_valid_o), 64'd0);
    check("rst_data",  64'(m_data_o),  64'd0);
    check("rst_keep",  64'(m_keep_o),  64'd0);
    check("rst_busy",  64'(busy_o),    64'd0);
    cycle(1'b0, 1'b0, 1'b1);

    // Four words form one full beat, lane 0 oldest.
    for (int i = 1; i <= 4; i++) fq.push_back(W'(i));
    repeat (4) cycle(1'b0, 1'b0, 1'b1);
    check("t1_data", 64'(m_data_o), 64'h0004_0003_0002_0001);
    check("t1_keep", 64'(m_keep_o), 64'hF);
    cycle(1'b0, 1'b0, 1'b1);

    // Eight words stream back-to-back with no idle pop cycle.
    for (int i = 0; i < 8; i++) fq.push_back(W'(16'h1000 + i));
    repeat (9) cycle(1'b0, 1'b0, 1'b1);

    // Output stalled: beat held, three more words accumulate, then pops stall.
    for (int i = 0; i < 12; i++) fq.push_back(W'(16'h2000 + i));
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    check("t3_hold", 64'(m_data_o), 64'h2003_2002_2001_2000);
    check("t3_stall", 64'(fifo_rd_en_o), 64'd0);
    repeat (12) cycle(1'b0, 1'b0, 1'b1);

    // Flush of a two-word partial beat, then flush with nothing buffered.
    fq.push_back(16'hAAAA);
    fq.push_back(16'hBBBB);
    repeat (2) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check("t4_data", 64'(m_data_o), 64'h0000_0000_BBBB_AAAA);
    check("t4_keep", 64'(m_keep_o), 64'h3);
    cycle(1'b0, 1'b1, 1'b1);
    check("t4_empty", 64'(m_valid_o), 64'd0);

    // Flush in the cycle the fourth word pops yields only the full beat.
    for (int i = 0; i < 4; i++) fq.push_back(W'(16'h5000 + i));
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check("t5_keep", 64'(m_keep_o), 64'hF);
    cycle(1'b0, 1'b1, 1'b1);
    check("t5_none", 64'(m_keep_o), 64'd0);

    // Reset with a pending beat and two buffered words.
    for (int i = 0; i < 6; i++) fq.push_back(W'(16'h6000 + i));
    repeat (6) cycle(1'b0, 1'b0, 1'b0);
    check("t6_busy", 64'(busy_o), 64'd1);
    cycle(1'b1, 1'b0, 1'b0);
    check("t6_valid", 64'(m_valid_o), 64'd0);
    check("t6_data",  64'(m_data_o),  64'd0);
    for (int i = 5; i <= 8; i++) fq.push_back(W'(i));
    repeat (4) cycle(1'b0, 1'b0, 1'b1);
    check("t6_lane0", 64'(m_data_o), 64'h0008_0007_0006_0005);

    // Randomized traffic, flushes, back-pressure and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      int n_push;
      n_push = int'($urandom_range(0, 2));
      for (int k = 0; k < n_push; k++)
        if (fq.size() < 16) fq.push_back(W'($urandom));
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 7));
    end
    fq.delete();
    repeat (6) cycle(1'b0, 1'b1, 1'b1);
    check("end_idle", 64'(busy_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
